// File: rtl/sap_pkg.sv
// Shared types and defaults for the SAP memory address unit.
package sap_pkg;

  localparam int unsigned SAP_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } blk_state_t;

endpackage

// File: rtl/memory_address_unit_if.sv
// Controller/RAM-side signal bundle for the memory address unit.
interface memory_address_unit_if
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP_ADDR_W
);

  logic [ADDR_W-1:0] BUS_IN;
  logic              _EN_MAR_IN;
  logic              MAR_INC;
  logic              _MAR_PROG;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic              BLK_START;
  logic [ADDR_W-1:0] BLK_BASE;
  logic [ADDR_W:0]   BLK_LEN;
  logic              BLK_ACK;
  logic [ADDR_W-1:0] ADDR_OUT;
  logic              BLK_REQ;
  logic              BLK_BUSY;
  logic              BLK_DONE;
  logic              WRAP;

  modport master (
    output BUS_IN, _EN_MAR_IN, MAR_INC, _MAR_PROG, PROG_ADDR,
           BLK_START, BLK_BASE, BLK_LEN, BLK_ACK,
    input  ADDR_OUT, BLK_REQ, BLK_BUSY, BLK_DONE, WRAP
  );

  modport slave (
    input  BUS_IN, _EN_MAR_IN, MAR_INC, _MAR_PROG, PROG_ADDR,
           BLK_START, BLK_BASE, BLK_LEN, BLK_ACK,
    output ADDR_OUT, BLK_REQ, BLK_BUSY, BLK_DONE, WRAP
  );

endinterface

// File: rtl/memory_address_unit_block_sequencer.sv
// Block-write sequencer: walks base..base+len-1 with a req/ack handshake.
module mar_block_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP_ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              blk_start,
  input  logic              prog_n,
  input  logic [ADDR_W-1:0] blk_base,
  input  logic [ADDR_W:0]   blk_len,
  input  logic              blk_ack,
  output logic [ADDR_W-1:0] blk_addr,
  output logic              blk_req,
  output logic              blk_busy,
  output logic              blk_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  blk_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  remaining, rem_nxt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      blk_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      blk_addr  <= addr_nxt;
      remaining <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = blk_addr;
    rem_nxt   = remaining;
    case (state)
      IDLE: begin
        if (blk_start && !prog_n) begin
          addr_nxt  = blk_base;
          rem_nxt   = blk_len;
          state_nxt = (blk_len != '0) ? REQ : DONE;
        end
      end
      REQ: begin
        // leaving programming mode aborts the block; a same-cycle ack is dropped
        if (prog_n) begin
          state_nxt = IDLE;
        end else if (blk_ack) begin
          rem_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = DONE;
          else                        addr_nxt  = blk_addr + ADDR_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign blk_req  = (state == REQ);
  assign blk_busy = (state != IDLE);
  assign blk_done = (state == DONE);

endmodule

// File: rtl/memory_address_unit.sv
// SAP memory address register with auto-increment, programming mux and block sequencer.
module memory_address_unit
  import sap_pkg::*;
#(
  parameter int unsigned     ADDR_W     = SAP_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                  CLOCK,
  input logic                  RESET,
  memory_address_unit_if.slave mau
);

  logic [ADDR_W-1:0] addr;
  logic              wrap_q;
  logic [ADDR_W-1:0] blk_addr;
  logic              blk_busy;

  // Load has priority over increment; WRAP flags an increment out of all-ones.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      addr   <= RESET_ADDR;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= mau._EN_MAR_IN && mau.MAR_INC && (&addr);
      if (!mau._EN_MAR_IN)  addr <= mau.BUS_IN;
      else if (mau.MAR_INC) addr <= addr + ADDR_W'(1);
    end
  end

  mar_block_sequencer #(.ADDR_W(ADDR_W)) u_seq (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .blk_start (mau.BLK_START),
    .prog_n    (mau._MAR_PROG),
    .blk_base  (mau.BLK_BASE),
    .blk_len   (mau.BLK_LEN),
    .blk_ack   (mau.BLK_ACK),
    .blk_addr  (blk_addr),
    .blk_req   (mau.BLK_REQ),
    .blk_busy  (blk_busy),
    .blk_done  (mau.BLK_DONE)
  );

  assign mau.BLK_BUSY = blk_busy;
  assign mau.WRAP     = wrap_q;

  // Zero-latency RAM address select.
  assign mau.ADDR_OUT = blk_busy         ? blk_addr      :
                        !mau._MAR_PROG   ? mau.PROG_ADDR : addr;

endmodule
